// File: rtl/mac_chain_pipe.sv
// rtl/mac_chain_pipe.sv - chained signed multiply-accumulate pipeline with skewed operand lines
//
// Computes dataout = datainC + sum_k(datainA_k * datainB_k) through N_TERMS
// chained stages. Each stage adds one product to the accumulator, with
// per-stage saturation or wrap. A sticky overflow flag travels with the vector.
// The whole pipeline advances only when the output slot is free or being drained.
//
// Ports:
//   clock    - rising-edge clock
//   reset    - synchronous active-high reset; clears valid bits, dataout and ovf
//   ivalid   - input vector presented
//   oready   - block accepts the input vector this cycle (== pipeline enable)
//   datainC  - signed initial accumulator value, ACC_W bits
//   datainA  - N_TERMS packed signed operands, term k at [k*DATA_W +: DATA_W]
//   datainB  - N_TERMS packed signed operands, same packing as datainA
//   ovalid   - dataout/ovf hold a valid result
//   iready   - downstream accepts the result this cycle
//   dataout  - signed result, ACC_W bits
//   ovf      - at least one stage saturated or wrapped for this result

`timescale 1ns/1ps

module mac_chain_pipe #(
  parameter int DATA_W    = 16,
  parameter int ACC_W     = 40,
  parameter int N_TERMS   = 4,
  parameter int STAGE_LAT = 2,
  parameter int SATURATE  = 1
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        ivalid,
  output logic                        oready,
  input  logic [ACC_W-1:0]            datainC,
  input  logic [N_TERMS*DATA_W-1:0]   datainA,
  input  logic [N_TERMS*DATA_W-1:0]   datainB,
  output logic                        ovalid,
  input  logic                        iready,
  output logic [ACC_W-1:0]            dataout,
  output logic                        ovf
);

  if (ACC_W < 2*DATA_W+1) begin : g_bad_acc_w
    $error("mac_chain_pipe: ACC_W must be at least 2*DATA_W+1");
  end
  if (N_TERMS < 1 || N_TERMS > 16) begin : g_bad_n_terms
    $error("mac_chain_pipe: N_TERMS must be in 1..16");
  end
  if (STAGE_LAT != 1 && STAGE_LAT != 2) begin : g_bad_stage_lat
    $error("mac_chain_pipe: STAGE_LAT must be 1 or 2");
  end

  localparam int PROD_W = 2*DATA_W;
  localparam logic [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

  // One global enable: every register (data, skew and valid) moves together,
  // so a stall freezes the whole pipeline and nothing can be lost or duplicated.
  logic en;
  assign en     = (iready | ~ovalid) & ~reset;
  assign oready = en;

  // Stage outputs, packed so each generate iteration drives its own slice.
  logic [N_TERMS*ACC_W-1:0] acc_bus;
  logic [N_TERMS-1:0]       v_bus;
  logic [N_TERMS-1:0]       ovf_bus;

  for (genvar k = 0; k < N_TERMS; k++) begin : g_stage
    logic signed [DATA_W-1:0] a_k;
    logic signed [DATA_W-1:0] b_k;
    logic        [ACC_W-1:0]  acc_in;
    logic                     v_in;
    logic                     ovf_in;

    if (k == 0) begin : g_head
      assign acc_in = datainC;
      assign v_in   = ivalid;
      assign ovf_in = 1'b0;
      assign a_k    = datainA[0 +: DATA_W];
      assign b_k    = datainB[0 +: DATA_W];
    end else begin : g_link
      // Term k enters stage k after k*STAGE_LAT enabled cycles, which is
      // exactly when the accumulator for the same vector arrives from stage k-1.
      localparam int D = k*STAGE_LAT;
      logic [DATA_W-1:0] skew_a [D];
      logic [DATA_W-1:0] skew_b [D];

      always_ff @(posedge clock) begin
        if (reset) begin
          for (int i = 0; i < D; i++) begin
            skew_a[i] <= '0;
            skew_b[i] <= '0;
          end
        end else if (en) begin
          skew_a[0] <= datainA[k*DATA_W +: DATA_W];
          skew_b[0] <= datainB[k*DATA_W +: DATA_W];
          for (int i = 1; i < D; i++) begin
            skew_a[i] <= skew_a[i-1];
            skew_b[i] <= skew_b[i-1];
          end
        end
      end

      assign a_k    = skew_a[D-1];
      assign b_k    = skew_b[D-1];
      assign acc_in = acc_bus[(k-1)*ACC_W +: ACC_W];
      assign v_in   = v_bus[k-1];
      assign ovf_in = ovf_bus[k-1];
    end

    logic signed [PROD_W-1:0] prod;
    assign prod = a_k * b_k;

    // Operands of the adder: either straight from the multiplier or from a
    // product register when the stage is split into two cycles.
    logic [PROD_W-1:0] prod_add;
    logic [ACC_W-1:0]  acc_add;
    logic              v_add;
    logic              ovf_add;

    if (STAGE_LAT == 2) begin : g_mul_reg
      always_ff @(posedge clock) begin
        if (reset) begin
          prod_add <= '0;
          acc_add  <= '0;
          v_add    <= 1'b0;
          ovf_add  <= 1'b0;
        end else if (en) begin
          prod_add <= prod;
          acc_add  <= acc_in;
          v_add    <= v_in;
          ovf_add  <= ovf_in;
        end
      end
    end else begin : g_mul_comb
      assign prod_add = prod;
      assign acc_add  = acc_in;
      assign v_add    = v_in;
      assign ovf_add  = ovf_in;
    end

    // One guard bit above ACC_W: overflow shows as the guard and the
    // accumulator sign bit disagreeing; the guard bit gives the true sign.
    logic [ACC_W:0]   sum_ext;
    logic             stage_ovf;
    logic [ACC_W-1:0] sum_res;

    assign sum_ext = {acc_add[ACC_W-1], acc_add}
                   + {{(ACC_W+1-PROD_W){prod_add[PROD_W-1]}}, prod_add};

    always_comb begin
      stage_ovf = sum_ext[ACC_W] ^ sum_ext[ACC_W-1];
      sum_res   = sum_ext[ACC_W-1:0];
      if (stage_ovf && SATURATE != 0) begin
        sum_res = sum_ext[ACC_W] ? ACC_MIN : ACC_MAX;
      end
    end

    logic [ACC_W-1:0] acc_r;
    logic             v_r;
    logic             ovf_r;

    always_ff @(posedge clock) begin
      if (reset) begin
        acc_r <= '0;
        v_r   <= 1'b0;
        ovf_r <= 1'b0;
      end else if (en) begin
        acc_r <= sum_res;
        v_r   <= v_add;
        ovf_r <= ovf_add | stage_ovf;
      end
    end

    assign acc_bus[k*ACC_W +: ACC_W] = acc_r;
    assign v_bus[k]                  = v_r;
    assign ovf_bus[k]                = ovf_r;
  end

  assign ovalid  = v_bus[N_TERMS-1];
  assign dataout = acc_bus[(N_TERMS-1)*ACC_W +: ACC_W];
  assign ovf     = ovf_bus[N_TERMS-1];

endmodule

// File: tb/tb_mac_chain_pipe.sv
// tb/tb_mac_chain_pipe.sv - scoreboard bench for mac_chain_pipe across several parameter sets

`timescale 1ns/1ps

module tb_mac_chain_pipe;

  localparam int DW   = 16;
  localparam int AW   = 40;
  localparam int MAXT = 7;
  localparam int NCFG = 6;

  localparam longint MAXV  = 64'sd549755813887;
  localparam longint MINV  = -64'sd549755813888;
  localparam longint TWO40 = 64'sd1099511627776;

  function automatic int cfg_nt(input int g);
    case (g)
      0, 1:    return 4;
      2, 4:    return 7;
      default: return 1;
    endcase
  endfunction

  function automatic int cfg_lat(input int g);
    case (g)
      2, 3:    return 1;
      default: return 2;
    endcase
  endfunction

  function automatic int cfg_sat(input int g);
    case (g)
      1, 4, 5: return 0;
      default: return 1;
    endcase
  endfunction

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic                reset  = 1'b1;
  logic                ivalid = 1'b0;
  logic                iready = 1'b1;
  logic                done   = 1'b0;
  logic [AW-1:0]       c_in   = '0;
  logic [MAXT*DW-1:0]  a_in   = '0;
  logic [MAXT*DW-1:0]  b_in   = '0;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: stage-by-stage accumulate in 64-bit integers, clamp or wrap
  // whenever the running sum leaves the 40-bit signed range.
  function automatic logic [AW:0] model(input logic [AW-1:0] c,
                                        input logic [MAXT*DW-1:0] a,
                                        input logic [MAXT*DW-1:0] b,
                                        input int nt, input int sat);
    longint acc, s, p;
    logic   o;
    logic signed [DW-1:0] ak, bk;
    acc = longint'($signed(c));
    o   = 1'b0;
    for (int k = 0; k < nt; k++) begin
      ak  = a[k*DW +: DW];
      bk  = b[k*DW +: DW];
      p   = longint'(ak) * longint'(bk);
      s   = acc + p;
      if (s > MAXV) begin
        o   = 1'b1;
        acc = (sat != 0) ? MAXV : s - TWO40;
      end else if (s < MINV) begin
        o   = 1'b1;
        acc = (sat != 0) ? MINV : s + TWO40;
      end else begin
        acc = s;
      end
    end
    return {o, acc[AW-1:0]};
  endfunction

  typedef struct {
    logic [AW:0] exp;
    int          stamp;
  } sb_t;

  for (genvar g = 0; g < NCFG; g++) begin : g_cfg
    localparam int NT  = cfg_nt(g);
    localparam int LAT = cfg_lat(g);
    localparam int SAT = cfg_sat(g);

    logic          oready_w, ovalid_w, ovf_w;
    logic [AW-1:0] dataout_w;
    sb_t           sb[$];
    sb_t           e;
    int            en_cnt = 0;
    logic          en_m;

    mac_chain_pipe #(
      .DATA_W(DW), .ACC_W(AW), .N_TERMS(NT), .STAGE_LAT(LAT), .SATURATE(SAT)
    ) dut (
      .clock  (clock),
      .reset  (reset),
      .ivalid (ivalid),
      .oready (oready_w),
      .datainC(c_in),
      .datainA(a_in[NT*DW-1:0]),
      .datainB(b_in[NT*DW-1:0]),
      .ovalid (ovalid_w),
      .iready (iready),
      .dataout(dataout_w),
      .ovf    (ovf_w)
    );

    // Monitor samples on the falling edge the handshakes that the next rising
    // edge will perform; en_cnt counts enabled edges for the latency check.
    always @(negedge clock) begin
      if (reset) begin
        sb.delete();
        check($sformatf("cfg%0d_oready_reset", g), 64'(oready_w), 64'd0);
      end else begin
        en_m = iready || !ovalid_w;
        check($sformatf("cfg%0d_oready", g), 64'(oready_w), 64'(en_m));
        if (ovalid_w) begin
          if (sb.size() == 0) begin
            check($sformatf("cfg%0d_spurious_ovalid", g), 64'(ovalid_w), 64'd0);
          end else begin
            check($sformatf("cfg%0d_dataout", g), 64'(dataout_w), 64'(sb[0].exp[AW-1:0]));
            check($sformatf("cfg%0d_ovf", g), 64'(ovf_w), 64'(sb[0].exp[AW]));
            if (iready) begin
              check($sformatf("cfg%0d_latency", g), 64'(en_cnt - sb[0].stamp), 64'(NT*LAT));
              void'(sb.pop_front());
            end
          end
        end
        if (ivalid && oready_w) begin
          e.exp   = model(c_in, a_in, b_in, NT, SAT);
          e.stamp = en_cnt;
          sb.push_back(e);
        end
        if (en_m) en_cnt++;
      end
    end

    always @(posedge done) begin
      check($sformatf("cfg%0d_drained", g), 64'(sb.size()), 64'd0);
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic rand_vec();
    for (int k = 0; k < MAXT; k++) begin
      a_in[k*DW +: DW] = 16'($urandom);
      b_in[k*DW +: DW] = 16'($urandom);
    end
    case ($urandom_range(0, 3))
      0:       c_in = 40'h7FFFFFFFFF - 40'($urandom_range(0, 1000));
      1:       c_in = 40'h8000000000 + 40'($urandom_range(0, 1000));
      default: c_in = {8'($urandom), 32'($urandom)};
    endcase
  endtask

  initial begin
    repeat (3) tick();

    // Reset state
    check("reset_ovalid",  64'(g_cfg[0].ovalid_w),  64'd0);
    check("reset_dataout", 64'(g_cfg[0].dataout_w), 64'd0);
    check("reset_ovf",     64'(g_cfg[0].ovf_w),     64'd0);
    check("reset_oready",  64'(g_cfg[0].oready_w),  64'd0);

    // First cycle out of reset accepts; single known vector, latency 8
    reset = 1'b0;
    #1;
    check("first_cycle_oready", 64'(g_cfg[0].oready_w), 64'd1);
    for (int k = 0; k < MAXT; k++) begin
      a_in[k*DW +: DW] = (k < 4) ? 16'(k + 1) : 16'd0;
      b_in[k*DW +: DW] = (k < 4) ? 16'(k + 5) : 16'd0;
    end
    c_in   = 40'd10;
    ivalid = 1'b1;
    tick();
    ivalid = 1'b0;
    repeat (6) tick();
    check("lat_early_ovalid", 64'(g_cfg[0].ovalid_w), 64'd0);
    tick();
    check("lat8_ovalid",  64'(g_cfg[0].ovalid_w),  64'd1);
    check("lat8_dataout", 64'(g_cfg[0].dataout_w), 64'd80);
    check("lat8_ovf",     64'(g_cfg[0].ovf_w),     64'd0);
    tick();
    check("single_pulse_ovalid", 64'(g_cfg[0].ovalid_w), 64'd0);
    repeat (8) tick();

    // Extreme operands: saturate vs wrap
    for (int k = 0; k < MAXT; k++) begin
      a_in[k*DW +: DW] = 16'h8000;
      b_in[k*DW +: DW] = 16'h8000;
    end
    c_in   = 40'h7FFFFFFFFF;
    ivalid = 1'b1;
    tick();
    ivalid = 1'b0;
    repeat (7) tick();
    check("sat_dataout",  64'(g_cfg[0].dataout_w), 64'h7FFFFFFFFF);
    check("sat_ovf",      64'(g_cfg[0].ovf_w),     64'd1);
    check("wrap_dataout", 64'(g_cfg[1].dataout_w), 64'h80FFFFFFFF);
    check("wrap_ovf",     64'(g_cfg[1].ovf_w),     64'd1);
    repeat (10) tick();

    // 20 back-to-back random vectors
    for (int i = 0; i < 20; i++) begin
      rand_vec();
      ivalid = 1'b1;
      tick();
    end
    ivalid = 1'b0;
    repeat (18) tick();

    // Output stall for 5 cycles while a result is waiting
    for (int i = 0; i < 6; i++) begin
      rand_vec();
      ivalid = 1'b1;
      tick();
    end
    for (int t = 0; t < 20 && !g_cfg[0].ovalid_w; t++) begin
      rand_vec();
      tick();
    end
    check("stall_reached_ovalid", 64'(g_cfg[0].ovalid_w), 64'd1);
    iready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      rand_vec();
      #1;
      check("stall_oready", 64'(g_cfg[0].oready_w), 64'd0);
      tick();
    end
    iready = 1'b1;
    ivalid = 1'b0;
    repeat (20) tick();

    // Reset with three vectors in flight
    for (int i = 0; i < 3; i++) begin
      rand_vec();
      ivalid = 1'b1;
      tick();
    end
    ivalid = 1'b0;
    repeat (2) tick();
    reset = 1'b1;
    #1;
    check("midreset_oready", 64'(g_cfg[0].oready_w), 64'd0);
    tick();
    reset = 1'b0;
    check("midreset_ovalid",  64'(g_cfg[0].ovalid_w),  64'd0);
    check("midreset_dataout", 64'(g_cfg[0].dataout_w), 64'd0);
    check("midreset_ovf",     64'(g_cfg[0].ovf_w),     64'd0);
    check("midreset_dataout_n7", 64'(g_cfg[2].dataout_w), 64'd0);
    for (int i = 0; i < 12; i++) begin
      tick();
      check("post_reset_ovalid", 64'(g_cfg[0].ovalid_w), 64'd0);
    end

    // Alternating ivalid with random iready
    for (int i = 0; i < 80; i++) begin
      rand_vec();
      ivalid = i[0];
      iready = ($urandom_range(0, 3) != 0);
      tick();
    end
    // Random ivalid and random iready
    for (int i = 0; i < 60; i++) begin
      rand_vec();
      ivalid = ($urandom_range(0, 1) != 0);
      iready = ($urandom_range(0, 2) != 0);
      tick();
    end
    ivalid = 1'b0;
    iready = 1'b1;
    repeat (30) tick();

    done = 1'b1;
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mac_chain_pipe.md
MAC_CHAIN_PIPE -- requirements
Module: mac_chain_pipe

Interface
REQ-001 The block SHALL have parameter DATA_W, default 16, meaning signed operand width.
REQ-002 The block SHALL have parameter ACC_W, default 40, meaning signed accumulator/result width; ACC_W >= 2*DATA_W+1 (elaboration error otherwise).
REQ-003 The block SHALL have parameter N_TERMS, default 4, meaning number of chained MAC stages (1..16).
REQ-004 The block SHALL have parameter STAGE_LAT, default 2, meaning per-stage latency in cycles, legal values 1 or 2.
REQ-005 The block SHALL have parameter SATURATE, default 1, meaning 1 = clamp on overflow, 0 = two's-complement wrap.
REQ-006 The block SHALL have port clock, input, 1, meaning the only clock; all logic on its rising edge.
REQ-007 The block SHALL have port reset, input, 1, meaning synchronous active-high reset.
REQ-008 The block SHALL have port ivalid, input, 1, meaning an input vector is presented.
REQ-009 The block SHALL have port oready, output, 1, meaning the block accepts the input vector this cycle.
REQ-010 The block SHALL have port datainC, input, ACC_W, meaning signed initial accumulator value.
REQ-011 The block SHALL have port datainA, input, N_TERMS*DATA_W, meaning signed operands; term k at bits [k*DATA_W +: DATA_W].
REQ-012 The block SHALL have port datainB, input, N_TERMS*DATA_W, meaning signed operands, same packing as datainA.
REQ-013 The block SHALL have port ovalid, output, 1, meaning dataout/ovf hold a valid result.
REQ-014 The block SHALL have port iready, input, 1, meaning downstream accepts the result this cycle.
REQ-015 The block SHALL have port dataout, output, ACC_W, meaning result C + sum(A_k*B_k).
REQ-016 The block SHALL have port ovf, output, 1, meaning saturation or wrap occurred in at least one stage of this result.

Function
REQ-017 Pipeline enable en SHALL be (iready OR NOT ovalid) AND NOT reset; oready SHALL equal en (combinational path iready->oready permitted).
REQ-018 A vector SHALL be captured when ivalid AND oready; when en is 0 every pipeline register, including the valid bits, SHALL hold.
REQ-019 When en is 1 and ivalid is 0, a bubble (valid bit 0) SHALL enter the pipeline; bubbles advance like data.
REQ-020 Stage k (0..N_TERMS-1) SHALL receive A_k and B_k delayed by k*STAGE_LAT enabled cycles through a per-term skew line, aligned with the accumulator from stage k-1 (stage 0 takes datainC).
REQ-021 Each stage SHALL form the full 2*DATA_W signed product, sign-extend it to ACC_W, and add it to the incoming accumulator.
REQ-022 STAGE_LAT=1: multiply and add SHALL be registered once per stage; STAGE_LAT=2: the product SHALL be registered, then the sum registered.
REQ-023 Latency from capture to ovalid SHALL be exactly N_TERMS*STAGE_LAT enabled cycles (8 at defaults); throughput SHALL be one vector per cycle with iready held high.
REQ-024 SATURATE=1: a stage sum exceeding the ACC_W signed range SHALL clamp to 2^(ACC_W-1)-1 or -2^(ACC_W-1); SATURATE=0: it SHALL wrap.
REQ-025 An ovf bit SHALL travel with each vector, OR-ing the overflow of every stage, and SHALL be presented with that vector's dataout.
REQ-026 The result SHALL remain stable on dataout/ovf while ovalid=1 and iready=0.
REQ-027 Results SHALL leave in acceptance order; no vector SHALL be dropped or duplicated under any iready pattern.

Reset
REQ-028 While reset=1 at a clock edge, all valid bits, ovalid, ovf and dataout SHALL become 0, and oready SHALL be 0 throughout.
REQ-029 Reset asserted mid-operation SHALL discard all in-flight vectors; none SHALL appear after reset deasserts.
REQ-030 The first vector after reset deasserts SHALL be acceptable in the first cycle with reset=0.

Verification
REQ-031 Defaults, A={1,2,3,4}, B={5,6,7,8}, C=10, one valid cycle, iready=1 -> ovalid one cycle, 8 cycles later, dataout=80, ovf=0.
REQ-032 20 back-to-back random vectors with iready=1 -> 20 consecutive ovalid cycles matching a reference model, in order.
REQ-033 ovalid=1, iready low for 5 cycles -> oready=0 and dataout/ovf held stable; 5 cycles later the stream resumes, with no loss.
REQ-034 A_k=B_k=-32768, C=2^39-1 -> SATURATE=1: dataout=2^39-1, ovf=1; SATURATE=0: dataout = wrapped value, ovf=1.
REQ-035 3 vectors in flight, reset pulsed 1 cycle -> ovalid stays 0 afterwards until a new vector completes, and dataout=0 after reset.
REQ-036 Alternating ivalid with random iready, N_TERMS=1 and 7, STAGE_LAT=1 and 2 -> order and values match the model, and the latency follows REQ-023.
